image_loader: RTL and testbench

IMAGE_LOADER -- requirements
Module: image_loader

---
 rtl/net_config.sv | 22 ++
 rtl/image_loader_if.sv | 39 +++
 rtl/image_loader.sv | 194 +++++++++++++++++++
 tb/tb_image_loader.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_config.sv
// Shared configuration for the classifier datapath: frame size, bus widths, loader states.
package net_config;

  localparam int unsigned NUM_PIXELS = 784;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned IDX_W      = 4;

  // Result index reported when no classification is available.
  localparam logic [IDX_W-1:0] IDX_NONE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    DRAIN,
    START,
    SETTLE,
    WAIT,
    RESULT
  } loader_state_t;

endpackage

// File: rtl/image_loader_if.sv
// Pixel stream, net_proc memory/control and result handshake of the image loader.
interface image_loader_if;
  import net_config::*;

  // Pixel stream in
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             s_last;

  // Data memory write port towards net_proc
  logic             mem_rst;
  logic             mem_we;
  logic [PIX_W-1:0] mem_wdata;

  // net_proc control
  logic             proc_start;
  logic             proc_done;
  logic [IDX_W-1:0] proc_idx;

  // Result out
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_idx;
  logic             res_err;

  // Loader side
  modport slave (
    input  s_valid, s_data, s_last, proc_done, proc_idx, res_ready,
    output s_ready, mem_rst, mem_we, mem_wdata, proc_start, res_valid, res_idx, res_err
  );

  // Environment side: stream source, net_proc and result sink
  modport master (
    output s_valid, s_data, s_last, proc_done, proc_idx, res_ready,
    input  s_ready, mem_rst, mem_we, mem_wdata, proc_start, res_valid, res_idx, res_err
  );

endinterface

// File: rtl/image_loader.sv
// Loads one pixel frame into net_proc memory, runs net_proc and reports the classified digit.
module image_loader #(
  parameter int unsigned NUM_PIXELS     = net_config::NUM_PIXELS,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic           clk,
  input  logic           rst_n,
  image_loader_if.slave  bus
);

  localparam int unsigned CNT_W = (NUM_PIXELS > 1)     ? $clog2(NUM_PIXELS)     : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned PIX_W = net_config::PIX_W;
  localparam int unsigned IDX_W = net_config::IDX_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PIXELS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  net_config::loader_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             settle_q, settle_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             s_ready_q, s_ready_d;
  logic             mem_rst_q, mem_rst_d;
  logic             mem_we_q, mem_we_d;
  logic [PIX_W-1:0] mem_wdata_q, mem_wdata_d;
  logic             proc_start_q, proc_start_d;
  logic             res_valid_q, res_valid_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic             res_err_q, res_err_d;

  logic             beat_c;

  // s_ready_q mirrors "state is LOAD or DRAIN", so this is the stream handshake.
  assign beat_c = bus.s_valid && s_ready_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= net_config::IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counters and registered output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    res_idx_d   = res_idx_q;
    res_err_d   = res_err_q;

    unique case (state_q)
      net_config::IDLE: begin
        // The waking beat is left on the bus and taken in LOAD.
        if (bus.s_valid) begin
          state_d = net_config::CLEAR;
        end
      end

      net_config::CLEAR: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = net_config::LOAD;
      end

      net_config::LOAD: begin
        if (beat_c) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = bus.s_data;
          if (cnt_q == CNT_LAST) begin
            if (bus.s_last) begin
              state_d = net_config::START;
            end else begin
              // Frame too long: memory is full, discard the rest but still classify.
              err_d   = 1'b1;
              state_d = net_config::DRAIN;
            end
          end else if (bus.s_last) begin
            // Frame too short: nothing sensible to classify.
            err_d     = 1'b1;
            res_err_d = 1'b1;
            res_idx_d = net_config::IDX_NONE;
            state_d   = net_config::RESULT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      net_config::DRAIN: begin
        if (beat_c && bus.s_last) begin
          state_d = net_config::START;
        end
      end

      net_config::START: begin
        settle_d = 1'b0;
        state_d  = net_config::SETTLE;
      end

      net_config::SETTLE: begin
        // net_proc may still show done from the previous run for a couple of cycles.
        if (settle_q) begin
          tmo_d   = '0;
          state_d = net_config::WAIT;
        end else begin
          settle_d = 1'b1;
        end
      end

      net_config::WAIT: begin
        if (bus.proc_done) begin
          res_idx_d = bus.proc_idx;
          res_err_d = err_q;
          state_d   = net_config::RESULT;
        end else if (tmo_q == TMO_LAST) begin
          err_d     = 1'b1;
          res_err_d = 1'b1;
          res_idx_d = net_config::IDX_NONE;
          state_d   = net_config::RESULT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      net_config::RESULT: begin
        if (bus.res_ready) begin
          state_d = net_config::IDLE;
        end
      end

      default: begin
        state_d = net_config::IDLE;
      end
    endcase

    // Moore-style outputs derived from the next state so they line up with state_q.
    s_ready_d   = (state_d == net_config::LOAD) || (state_d == net_config::DRAIN);
    mem_rst_d   = (state_d == net_config::CLEAR);
    res_valid_d = (state_d == net_config::RESULT);
    // Issued the cycle after START so it trails the final memory write by one cycle.
    proc_start_d = (state_q == net_config::START);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      err_q        <= 1'b0;
      settle_q     <= 1'b0;
      tmo_q        <= '0;
      s_ready_q    <= 1'b0;
      mem_rst_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      proc_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_idx_q    <= '0;
      res_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      settle_q     <= settle_d;
      tmo_q        <= tmo_d;
      s_ready_q    <= s_ready_d;
      mem_rst_q    <= mem_rst_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      proc_start_q <= proc_start_d;
      res_valid_q  <= res_valid_d;
      res_idx_q    <= res_idx_d;
      res_err_q    <= res_err_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.mem_rst    = mem_rst_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.proc_start = proc_start_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_idx    = res_idx_q;
  assign bus.res_err    = res_err_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: frame length cases, timeout, result hold, reset recovery.
module tb_image_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  image_loader_if ifc();
  image_loader_if ift();

  image_loader u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  image_loader #(
    .NUM_PIXELS     (4),
    .TIMEOUT_CYCLES (64)
  ) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ift)
  );

  int checks = 0;
  int errors = 0;

  // Output monitor for the main instance; frame write index restarts on each mem_rst.
  int cyc = 0;
  int rst_cnt = 0;
  int we_frame = 0;
  int ord_err = 0;
  int start_cnt = 0;
  int last_we_cyc = 0;
  int last_start_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (ifc.mem_rst) begin
        rst_cnt  <= rst_cnt + 1;
        we_frame <= 0;
      end else if (ifc.mem_we) begin
        if (ifc.mem_wdata !== 8'(we_frame % 256)) ord_err <= ord_err + 1;
        we_frame    <= we_frame + 1;
        last_we_cyc <= cyc;
      end
      if (ifc.proc_start) begin
        start_cnt      <= start_cnt + 1;
        last_start_cyc <= cyc;
      end
    end
  end

  // net_proc stand-in: done drops after start, rises done_delay cycles later and stays up.
  int         done_delay = 10;
  logic [3:0] done_idx   = 4'd0;

  initial begin
    int pcnt;
    pcnt = 0;
    ifc.proc_done = 1'b0;
    ifc.proc_idx  = 4'd0;
    forever begin
      @(negedge clk);
      if (ifc.proc_start) begin
        ifc.proc_done = 1'b0;
        pcnt = done_delay;
      end else if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 0) begin
          ifc.proc_done = 1'b1;
          ifc.proc_idx  = done_idx;
        end
      end
    end
  end

  // Beat i carries i mod 256; s_last on beat last_at (-1: never).
  task automatic send_frame(input int nbeats, input int last_at, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      int guard;
      bit acc;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        ifc.s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      ifc.s_valid = 1'b1;
      ifc.s_data  = 8'(i % 256);
      ifc.s_last  = (i == last_at);
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        acc = ifc.s_ready;
        @(negedge clk);
        guard++;
      end
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL beat_accept: beat %0d s_ready=%b, required 1 within 50 cycles", i, ifc.s_ready);
        break;
      end
    end
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
  endtask

  task automatic wait_result(input string name, input int budget);
    int n;
    n = 0;
    while (ifc.res_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ifc.res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_res_valid: res_valid=%b after %0d cycles, required 1", name, ifc.res_valid, n);
    end
    @(negedge clk);
  endtask

  task automatic ack_result(input string name);
    ifc.res_ready = 1'b1;
    @(negedge clk);
    ifc.res_ready = 1'b0;
    checks++;
    if (ifc.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: res_valid=%b after res_ready, required 0", name, ifc.res_valid);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifc.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b required 0", ifc.s_ready); end
    checks++; if (ifc.mem_rst !== 1'b0) begin errors++; $display("FAIL rst_mem_rst: got %b required 0", ifc.mem_rst); end
    checks++; if (ifc.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b required 0", ifc.mem_we); end
    checks++; if (ifc.mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata: got %h required 00", ifc.mem_wdata); end
    checks++; if (ifc.proc_start !== 1'b0) begin errors++; $display("FAIL rst_proc_start: got %b required 0", ifc.proc_start); end
    checks++; if (ifc.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b required 0", ifc.res_valid); end
    checks++; if (ifc.res_idx !== 4'h0) begin errors++; $display("FAIL rst_res_idx: got %h required 0", ifc.res_idx); end
    checks++; if (ifc.res_err !== 1'b0) begin errors++; $display("FAIL rst_res_err: got %b required 0", ifc.res_err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ifc.s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready: got %b required 0", ifc.s_ready); end
  endtask

  task automatic test_full_frame();
    int b_rst, b_start, b_ord;
    b_rst = rst_cnt; b_start = start_cnt; b_ord = ord_err;
    done_delay = 500; done_idx = 4'd7;
    send_frame(784, 783, 1'b0);
    wait_result("full", 2000);
    checks++; if (rst_cnt - b_rst !== 1) begin errors++; $display("FAIL full_mem_rst: got %0d pulses required 1", rst_cnt - b_rst); end
    checks++; if (we_frame !== 784) begin errors++; $display("FAIL full_mem_we: got %0d writes required 784", we_frame); end
    checks++; if (ord_err !== b_ord) begin errors++; $display("FAIL full_wdata_order: got %0d bad bytes required 0", ord_err - b_ord); end
    checks++; if (start_cnt - b_start !== 1) begin errors++; $display("FAIL full_proc_start: got %0d pulses required 1", start_cnt - b_start); end
    checks++; if (last_start_cyc <= last_we_cyc) begin errors++; $display("FAIL full_start_after_we: start cycle %0d last write cycle %0d, required later", last_start_cyc, last_we_cyc); end
    checks++; if (ifc.res_idx !== 4'd7) begin errors++; $display("FAIL full_res_idx: got %h required 7", ifc.res_idx); end
    checks++; if (ifc.res_err !== 1'b0) begin errors++; $display("FAIL full_res_err: got %b required 0", ifc.res_err); end
    checks++; if (ifc.s_ready !== 1'b0) begin errors++; $display("FAIL full_result_s_ready: got %b required 0", ifc.s_ready); end
    ack_result("full");
  endtask

  task automatic test_short_frame();
    int b_rst, b_start;
    b_rst = rst_cnt; b_start = start_cnt;
    send_frame(100, 99, 1'b0);
    wait_result("short", 200);
    checks++; if (rst_cnt - b_rst !== 1) begin errors++; $display("FAIL short_mem_rst: got %0d pulses required 1", rst_cnt - b_rst); end
    checks++; if (we_frame !== 100) begin errors++; $display("FAIL short_mem_we: got %0d writes required 100", we_frame); end
    checks++; if (start_cnt !== b_start) begin errors++; $display("FAIL short_proc_start: got %0d pulses required 0", start_cnt - b_start); end
    checks++; if (ifc.res_idx !== 4'hF) begin errors++; $display("FAIL short_res_idx: got %h required F", ifc.res_idx); end
    checks++; if (ifc.res_err !== 1'b1) begin errors++; $display("FAIL short_res_err: got %b required 1", ifc.res_err); end
    ack_result("short");
  endtask

  task automatic test_long_frame();
    int b_start, b_ord;
    b_start = start_cnt; b_ord = ord_err;
    done_delay = 40; done_idx = 4'd3;
    send_frame(790, 789, 1'b0);
    wait_result("long", 500);
    checks++; if (we_frame !== 784) begin errors++; $display("FAIL long_mem_we: got %0d writes required 784", we_frame); end
    checks++; if (ord_err !== b_ord) begin errors++; $display("FAIL long_wdata_order: got %0d bad bytes required 0", ord_err - b_ord); end
    checks++; if (start_cnt - b_start !== 1) begin errors++; $display("FAIL long_proc_start: got %0d pulses required 1", start_cnt - b_start); end
    checks++; if (ifc.res_idx !== 4'd3) begin errors++; $display("FAIL long_res_idx: got %h required 3", ifc.res_idx); end
    checks++; if (ifc.res_err !== 1'b1) begin errors++; $display("FAIL long_res_err: got %b required 1", ifc.res_err); end
    ack_result("long");
  endtask

  task automatic test_hold();
    int b_start, b_ord;
    b_start = start_cnt; b_ord = ord_err;
    done_delay = 30; done_idx = 4'd5;
    send_frame(784, 783, 1'b1);
    wait_result("hold", 500);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (ifc.res_valid !== 1'b1 || ifc.res_idx !== 4'd5 || ifc.res_err !== 1'b0) begin
        errors++;
        $display("FAIL hold_result: cycle %0d valid=%b idx=%h err=%b, required 1/5/0", i, ifc.res_valid, ifc.res_idx, ifc.res_err);
      end
      @(negedge clk);
    end
    checks++; if (we_frame !== 784) begin errors++; $display("FAIL hold_mem_we: got %0d writes required 784", we_frame); end
    checks++; if (ord_err !== b_ord) begin errors++; $display("FAIL hold_wdata_order: got %0d bad bytes required 0", ord_err - b_ord); end
    checks++; if (start_cnt - b_start !== 1) begin errors++; $display("FAIL hold_proc_start: got %0d pulses required 1", start_cnt - b_start); end
    ack_result("hold");
  endtask

  task automatic test_back_to_back();
    int b_rst;
    send_frame(20, 19, 1'b0);
    wait_result("b2b_first", 200);
    b_rst = rst_cnt;
    ifc.res_ready = 1'b1;
    ifc.s_valid   = 1'b1;
    ifc.s_data    = 8'h00;
    ifc.s_last    = 1'b0;
    @(negedge clk);
    ifc.res_ready = 1'b0;
    checks++; if (ifc.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_release: res_valid=%b required 0", ifc.res_valid); end
    send_frame(10, 9, 1'b0);
    wait_result("b2b_second", 200);
    checks++; if (rst_cnt - b_rst !== 1) begin errors++; $display("FAIL b2b_mem_rst: got %0d pulses required 1", rst_cnt - b_rst); end
    checks++; if (we_frame !== 10) begin errors++; $display("FAIL b2b_mem_we: got %0d writes required 10", we_frame); end
    checks++; if (ifc.res_idx !== 4'hF || ifc.res_err !== 1'b1) begin errors++; $display("FAIL b2b_result: idx=%h err=%b required F/1", ifc.res_idx, ifc.res_err); end
    ack_result("b2b");
  endtask

  task automatic test_reset_mid_frame();
    int b_rst, b_start, b_ord;
    done_delay = 50; done_idx = 4'd2;
    send_frame(300, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.s_ready, ifc.mem_rst, ifc.mem_we, ifc.mem_wdata, ifc.proc_start,
         ifc.res_valid, ifc.res_idx, ifc.res_err} !== 18'h0) begin
      errors++;
      $display("FAIL midrst_outputs: s_ready=%b mem_we=%b wdata=%h valid=%b idx=%h err=%b, required all 0",
               ifc.s_ready, ifc.mem_we, ifc.mem_wdata, ifc.res_valid, ifc.res_idx, ifc.res_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b_rst = rst_cnt; b_start = start_cnt; b_ord = ord_err;
    send_frame(784, 783, 1'b0);
    wait_result("midrst", 500);
    checks++; if (rst_cnt - b_rst !== 1) begin errors++; $display("FAIL midrst_mem_rst: got %0d pulses required 1", rst_cnt - b_rst); end
    checks++; if (we_frame !== 784) begin errors++; $display("FAIL midrst_mem_we: got %0d writes required 784", we_frame); end
    checks++; if (ord_err !== b_ord) begin errors++; $display("FAIL midrst_wdata_order: got %0d bad bytes required 0", ord_err - b_ord); end
    checks++; if (start_cnt - b_start !== 1) begin errors++; $display("FAIL midrst_proc_start: got %0d pulses required 1", start_cnt - b_start); end
    checks++; if (ifc.res_idx !== 4'd2 || ifc.res_err !== 1'b0) begin errors++; $display("FAIL midrst_result: idx=%h err=%b required 2/0", ifc.res_idx, ifc.res_err); end
    ack_result("midrst");
  endtask

  // 4-pixel instance with a 64-cycle timeout and a net_proc that never finishes.
  task automatic test_timeout();
    int n;
    for (int i = 0; i < 4; i++) begin
      int guard;
      bit acc;
      ift.s_valid = 1'b1;
      ift.s_data  = 8'(i);
      ift.s_last  = (i == 3);
      acc = 1'b0; guard = 0;
      while (!acc && guard < 50) begin
        acc = ift.s_ready;
        @(negedge clk);
        guard++;
      end
      checks++;
      if (!acc) begin errors++; $display("FAIL tmo_beat_accept: beat %0d s_ready=%b required 1", i, ift.s_ready); break; end
    end
    ift.s_valid = 1'b0;
    ift.s_last  = 1'b0;
    n = 0;
    while (ift.proc_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (ift.proc_start !== 1'b1) begin errors++; $display("FAIL tmo_proc_start: got %b required 1", ift.proc_start); end
    n = 0;
    while (ift.res_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n !== 66) begin errors++; $display("FAIL tmo_latency: res_valid %0d cycles after proc_start, required 66", n); end
    checks++; if (ift.res_idx !== 4'hF) begin errors++; $display("FAIL tmo_res_idx: got %h required F", ift.res_idx); end
    checks++; if (ift.res_err !== 1'b1) begin errors++; $display("FAIL tmo_res_err: got %b required 1", ift.res_err); end
    ift.res_ready = 1'b1;
    @(negedge clk);
    ift.res_ready = 1'b0;
    checks++; if (ift.res_valid !== 1'b0) begin errors++; $display("FAIL tmo_ack: res_valid=%b required 0", ift.res_valid); end
  endtask

  initial begin
    ifc.s_valid   = 1'b0;
    ifc.s_data    = 8'h00;
    ifc.s_last    = 1'b0;
    ifc.res_ready = 1'b0;
    ift.s_valid   = 1'b0;
    ift.s_data    = 8'h00;
    ift.s_last    = 1'b0;
    ift.res_ready = 1'b0;
    ift.proc_done = 1'b0;
    ift.proc_idx  = 4'h0;

    test_reset();
    test_full_frame();
    test_short_frame();
    test_long_frame();
    test_hold();
    test_back_to_back();
    test_reset_mid_frame();
    test_timeout();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
